// File: rtl/bus_pkg.sv
// bus_pkg
// Shared definitions for the master bus port: FSM state encoding, control
// frame constants and the frame-length helper.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CTRL,
    WRITE,
    READ,
    DONE
  } bus_state_t;

  // First bit of every control frame.
  localparam logic START_BIT = 1'b1;

  // Last bit of the control frame encodes the transfer direction.
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Control frame length: start bit, slave id, R/W bit.
  function automatic int frame_len(input int id_w);
    return 2 + id_w;
  endfunction

endpackage

// File: rtl/master_bus_port_if.sv
// master_bus_port_if
// Groups the command/response handshake and the serial slave-side bus of
// the master bus port.
//   master modport : the port itself (takes commands, drives the serial bus)
//   slave modport  : the local master logic plus the serial slave
// Signals:
//   cmd_valid/cmd_ready/cmd_slave_id/cmd_write/cmd_wdata : command request
//   rsp_valid/rsp_rdata/rsp_error                       : one-cycle response
//   control/wD/valid                                    : serial outputs
//   rD/ready                                            : serial inputs
interface master_bus_port_if #(
  parameter int SLAVES     = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ID_W-1:0]       cmd_slave_id;
  logic                  cmd_write;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;
  logic                  control;
  logic                  wD;
  logic                  valid;
  logic                  rD;
  logic                  ready;

  modport master (
    input  cmd_valid, cmd_slave_id, cmd_write, cmd_wdata, rD, ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, control, wD, valid
  );

  modport slave (
    output cmd_valid, cmd_slave_id, cmd_write, cmd_wdata, rD, ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, control, wD, valid
  );

endinterface

// File: rtl/bus_shift_reg.sv
// bus_shift_reg
// WIDTH-bit shift register with parallel load. Shifting moves every bit one
// place towards the MSB and inserts shift_in at the LSB, so the MSB is the
// next serial output bit and serial input accumulates MSB first.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears contents)
//   load      : parallel load of load_data (has priority over shift_en)
//   shift_en  : shift one position
//   shift_in  : bit entering the LSB
//   q         : current contents
//   msb       : q[WIDTH-1]
module bus_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic [WIDTH-1:0] q,
  output logic             msb
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      // Truncating cast drops the old MSB, which has already been sent.
      q <= WIDTH'({q, shift_in});
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/master_bus_port.sv
// master_bus_port
// Master-side serial bus port. Accepts one command, serialises a control
// frame (start, slave id MSB first, R/W) on control, then shifts write data
// out on wD/valid or collects read data from rD/ready, and finishes with a
// one-cycle response. A TIMEOUT-cycle run without progress aborts with
// rsp_error; an out-of-range slave id errors without touching the bus.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : master_bus_port_if.master (command, response and serial bus)
// All outputs are registered except cmd_ready, which is (state == IDLE).
module master_bus_port
  import bus_pkg::*;
#(
  parameter int SLAVES     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  master_bus_port_if.master bus
);

  localparam int ID_W    = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int FL      = frame_len(ID_W);
  localparam int CNT_MAX = (DATA_WIDTH > FL) ? DATA_WIDTH : FL;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FL - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_WIDTH);
  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT);
  localparam logic [ID_W:0]    ID_LIMIT   = (ID_W + 1)'(SLAVES);

  bus_state_t            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [ID_W:0]         frame_q, frame_d;
  logic                  write_q, write_d;
  logic                  control_q, control_d;
  logic                  wd_q, wd_d;
  logic                  valid_q, valid_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  sr_load, sr_shift, sr_in, sr_msb;
  logic [DATA_WIDTH-1:0] sr_q;

  logic                  illegal_id;
  logic                  issue;
  logic [CNT_W-1:0]      sent_cnt;
  logic [TO_W-1:0]       wait_cnt;

  assign illegal_id = ({1'b0, bus.cmd_slave_id} >= ID_LIMIT);

  // One shift register serves both directions: loaded with the write word
  // on acceptance, or filled from rD during a read.
  bus_shift_reg #(.WIDTH(DATA_WIDTH)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (sr_load),
    .load_data (bus.cmd_wdata),
    .shift_en  (sr_shift),
    .shift_in  (sr_in),
    .q         (sr_q),
    .msb       (sr_msb)
  );

  // State and registered outputs; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      frame_q     <= '0;
      write_q     <= 1'b0;
      control_q   <= 1'b0;
      wd_q        <= 1'b0;
      valid_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      frame_q     <= frame_d;
      write_q     <= write_d;
      control_q   <= control_d;
      wd_q        <= wd_d;
      valid_q     <= valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next state and next output values. Outputs are computed one cycle
  // ahead so that each registered output lines up with its state's cycle.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    frame_d     = frame_q;
    write_d     = write_q;
    control_d   = 1'b0;
    wd_d        = 1'b0;
    valid_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = '0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_in       = 1'b0;
    issue       = 1'b0;
    sent_cnt    = bit_cnt_q;
    wait_cnt    = to_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (illegal_id) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            state_d   = CTRL;
            control_d = START_BIT;
            frame_d   = {bus.cmd_slave_id, bus.cmd_write};
            write_d   = bus.cmd_write;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            sr_load   = 1'b1;
          end
        end
      end

      CTRL: begin
        if (bit_cnt_q == FRAME_LAST) begin
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          if (write_q == RW_WRITE) begin
            // The first data bit is decided in the last frame cycle so it
            // appears right after the frame.
            state_d  = WRITE;
            issue    = 1'b1;
            sent_cnt = '0;
            wait_cnt = '0;
          end else begin
            state_d = READ;
          end
        end else begin
          control_d = frame_q[ID_W];
          frame_d   = frame_q << 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      WRITE: begin
        issue = 1'b1;
      end

      READ: begin
        if (!bus.ready) begin
          sr_shift  = 1'b1;
          sr_in     = bus.rD;
          to_cnt_d  = '0;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q + CNT_W'(1) == DATA_LAST) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = DATA_WIDTH'({sr_q, bus.rD});
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_q + TO_W'(1) == TO_MAX) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end
        end
      end

      DONE: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Write-bit issue: ready in this cycle decides whether the next cycle
    // carries a valid bit; during a stall wD keeps the last bit shown.
    if (issue) begin
      if (sent_cnt == DATA_LAST) begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
      end else if (bus.ready) begin
        valid_d   = 1'b1;
        wd_d      = sr_msb;
        sr_shift  = 1'b1;
        bit_cnt_d = sent_cnt + CNT_W'(1);
        to_cnt_d  = '0;
      end else begin
        wd_d     = wd_q;
        to_cnt_d = wait_cnt + TO_W'(1);
        if (wait_cnt + TO_W'(1) == TO_MAX) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.control   = control_q;
  assign bus.wD        = wd_q;
  assign bus.valid     = valid_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_master_bus_port.sv
// tb_master_bus_port
// Directed bench for master_bus_port (SLAVES=3, DATA_WIDTH=8, TIMEOUT=16).
// Each transaction gets a per-cycle ready/rD schedule relative to the
// acceptance cycle; a timeline model turns command + schedule into expected
// per-cycle outputs, which one compare process checks every cycle. Hand
// values for latency, data and frame pin the model.
module tb_master_bus_port;

  localparam int SLAVES = 3;
  localparam int DW     = 8;
  localparam int TO     = 16;
  localparam int FL     = 4;
  localparam int MAXC   = 64;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  master_bus_port_if #(.SLAVES(SLAVES), .DATA_WIDTH(DW)) bus ();

  master_bus_port #(
    .SLAVES     (SLAVES),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic          exp_ctrl  [MAXC];
  logic          exp_wd    [MAXC];
  logic          exp_valid [MAXC];
  logic          exp_rsp   [MAXC];
  logic          exp_err   [MAXC];
  logic          exp_rdy   [MAXC];
  logic [DW-1:0] exp_rdata [MAXC];
  logic          rdy_sched [MAXC];
  logic          rd_sched  [MAXC];

  int            k;
  int            rsp_at;
  int            checks = 0;
  int            errors = 0;
  logic          chk_en = 1'b0;

  int            seen_rsp_at;
  logic          seen_err;
  logic [DW-1:0] seen_rdata;
  logic [DW-1:0] wd_word;
  logic [FL-1:0] ctrl_word;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  task automatic set_defaults();
    for (int i = 0; i < MAXC; i++) begin
      rdy_sched[i] = 1'b1;
      rd_sched[i]  = 1'b0;
    end
  endtask

  // Timeline model: walk the transaction cycle by cycle from the rules of
  // the protocol (frame bits, then one bit per ready cycle, timeout after
  // TO idle cycles, response one cycle after the last event).
  task automatic build_model(input int id, input bit wr, input logic [DW-1:0] wdata);
    int            c, sent, waitc, n;
    logic          held;
    logic [DW-1:0] word, wsh;
    logic [FL-1:0] frame;
    for (int i = 0; i < MAXC; i++) begin
      exp_ctrl[i]  = 1'b0;
      exp_wd[i]    = 1'b0;
      exp_valid[i] = 1'b0;
      exp_rsp[i]   = 1'b0;
      exp_err[i]   = 1'b0;
      exp_rdy[i]   = 1'b0;
      exp_rdata[i] = '0;
    end
    exp_rdy[0] = 1'b1;
    rsp_at = -1;
    if (id >= SLAVES) begin
      rsp_at = 1;
      exp_err[1] = 1'b1;
    end else begin
      frame = {1'b1, 2'(id), wr};
      for (int i = 0; i < FL; i++) begin
        exp_ctrl[1 + i] = frame[FL-1];
        frame = frame << 1;
      end
      if (wr) begin
        c = FL; sent = 0; waitc = 0; held = 1'b0; wsh = wdata;
        while (rsp_at < 0 && c < MAXC - 2) begin
          if (sent == DW) begin
            rsp_at = c + 1;
          end else if (rdy_sched[c]) begin
            held = wsh[DW-1];
            wsh = wsh << 1;
            exp_valid[c + 1] = 1'b1;
            exp_wd[c + 1] = held;
            sent++;
            waitc = 0;
          end else begin
            exp_wd[c + 1] = held;
            waitc++;
            if (waitc == TO) begin
              rsp_at = c + 1;
              exp_err[c + 1] = 1'b1;
            end
          end
          c++;
        end
      end else begin
        c = FL + 1; n = 0; waitc = 0; word = '0;
        while (rsp_at < 0 && c < MAXC - 2) begin
          if (!rdy_sched[c]) begin
            word = {word[DW-2:0], rd_sched[c]};
            n++;
            waitc = 0;
            if (n == DW) begin
              rsp_at = c + 1;
              exp_rdata[c + 1] = word;
            end
          end else begin
            waitc++;
            if (waitc == TO) begin
              rsp_at = c + 1;
              exp_err[c + 1] = 1'b1;
            end
          end
          c++;
        end
      end
    end
    if (rsp_at > 0) begin
      exp_rsp[rsp_at] = 1'b1;
      for (int i = rsp_at + 1; i < MAXC; i++) exp_rdy[i] = 1'b1;
    end
  endtask

  // Compare process: every cycle of a transaction, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check_output("cmd_ready", bus.cmd_ready, exp_rdy[k]);
      check_output("control",   bus.control,   exp_ctrl[k]);
      check_output("wD",        bus.wD,        exp_wd[k]);
      check_output("valid",     bus.valid,     exp_valid[k]);
      check_output("rsp_valid", bus.rsp_valid, exp_rsp[k]);
      check_output("rsp_error", bus.rsp_error, exp_err[k]);
      check_output("rsp_rdata", bus.rsp_rdata, exp_rdata[k]);
      if (bus.rsp_valid && seen_rsp_at < 0) begin
        seen_rsp_at = k;
        seen_err    = bus.rsp_error;
        seen_rdata  = bus.rsp_rdata;
      end
      if (bus.valid) wd_word = {wd_word[DW-2:0], bus.wD};
      if (k >= 1 && k <= FL) ctrl_word = {ctrl_word[FL-2:0], bus.control};
    end
  end

  // Issue one command at cycle 0 and play the schedules until one cycle
  // past the expected response; command inputs are scrambled afterwards.
  task automatic apply_stimulus(input int id, input bit wr, input logic [DW-1:0] data);
    int last;
    build_model(id, wr, data);
    last = (rsp_at < 0) ? MAXC - 3 : rsp_at + 1;
    seen_rsp_at = -1;
    seen_err    = 1'b0;
    seen_rdata  = '0;
    wd_word     = '0;
    ctrl_word   = '0;
    @(posedge clk); #1;
    k = 0;
    bus.cmd_valid    = 1'b1;
    bus.cmd_slave_id = 2'(id);
    bus.cmd_write    = wr;
    bus.cmd_wdata    = data;
    bus.ready        = rdy_sched[0];
    bus.rD           = rd_sched[0];
    chk_en = 1'b1;
    while (k < last) begin
      @(posedge clk); #1;
      k++;
      bus.cmd_valid    = 1'b0;
      bus.cmd_slave_id = ~bus.cmd_slave_id;
      bus.cmd_write    = ~bus.cmd_write;
      bus.cmd_wdata    = ~bus.cmd_wdata;
      bus.ready        = rdy_sched[k];
      bus.rD           = rd_sched[k];
    end
    @(negedge clk);
    #1;
    chk_en    = 1'b0;
    bus.ready = 1'b1;
    bus.rD    = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] pat;
    int            pulses;
    rst = 1'b0;
    k = 0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_slave_id = '0;
    bus.cmd_write    = 1'b0;
    bus.cmd_wdata    = '0;
    bus.ready        = 1'b1;
    bus.rD           = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_cmd_ready", bus.cmd_ready, 1);
    check_output("reset_control",   bus.control,   0);
    check_output("reset_wD",        bus.wD,        0);
    check_output("reset_valid",     bus.valid,     0);
    check_output("reset_rsp_valid", bus.rsp_valid, 0);
    check_output("reset_rsp_rdata", bus.rsp_rdata, 0);
    rst = 1'b0;

    // Write id=2, 0xA5, no stalls.
    set_defaults();
    apply_stimulus(2, 1'b1, 8'hA5);
    check_output("w_a5_latency", seen_rsp_at, 13);
    check_output("w_a5_error",   seen_err,    0);
    check_output("w_a5_serial",  wd_word,     8'hA5);
    check_output("w_a5_frame",   ctrl_word,   4'b1101);

    // Write 0x3C with ready low for 3 cycles after the 4th bit.
    set_defaults();
    for (int i = 8; i <= 10; i++) rdy_sched[i] = 1'b0;
    apply_stimulus(0, 1'b1, 8'h3C);
    check_output("w_stall_latency", seen_rsp_at, 16);
    check_output("w_stall_serial",  wd_word,     8'h3C);

    // Read id=1, slave answers 0x5A on cycles 6..13.
    set_defaults();
    pat = 8'h5A;
    for (int i = 0; i < DW; i++) begin
      rdy_sched[6 + i] = 1'b0;
      rd_sched[6 + i]  = pat[DW-1];
      pat = pat << 1;
    end
    apply_stimulus(1, 1'b0, 8'h00);
    check_output("r_5a_latency", seen_rsp_at, 14);
    check_output("r_5a_rdata",   seen_rdata,  8'h5A);
    check_output("r_5a_error",   seen_err,    0);
    check_output("r_5a_frame",   ctrl_word,   4'b1010);

    // Read with ready stuck high: timeout.
    set_defaults();
    for (int i = 0; i < MAXC; i++) rd_sched[i] = 1'b1;
    apply_stimulus(2, 1'b0, 8'h00);
    check_output("r_to_latency", seen_rsp_at, 21);
    check_output("r_to_error",   seen_err,    1);
    check_output("r_to_rdata",   seen_rdata,  0);

    // Illegal id straight after the timeout.
    set_defaults();
    apply_stimulus(3, 1'b1, 8'h77);
    check_output("bad_id_latency", seen_rsp_at, 1);
    check_output("bad_id_error",   seen_err,    1);
    check_output("bad_id_frame",   ctrl_word,   0);

    // Write with the slave never ready: timeout.
    set_defaults();
    for (int i = 4; i < MAXC; i++) rdy_sched[i] = 1'b0;
    apply_stimulus(1, 1'b1, 8'hFF);
    check_output("w_to_latency", seen_rsp_at, 20);
    check_output("w_to_error",   seen_err,    1);
    check_output("w_to_serial",  wd_word,     0);

    // Reset in the middle of write data.
    set_defaults();
    @(posedge clk); #1;
    bus.cmd_valid    = 1'b1;
    bus.cmd_slave_id = 2'd2;
    bus.cmd_write    = 1'b1;
    bus.cmd_wdata    = 8'hFF;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    check_output("rst_pre_valid", bus.valid, 1);
    check_output("rst_pre_wD",    bus.wD,    1);
    rst = 1'b1;
    #1;
    check_output("rst_wD",        bus.wD,        0);
    check_output("rst_valid",     bus.valid,     0);
    check_output("rst_control",   bus.control,   0);
    check_output("rst_rsp_valid", bus.rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
    end
    check_output("rst_no_rsp",    pulses,        0);
    check_output("rst_cmd_ready", bus.cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
